div_seq: RTL and testbench
==========================

# div_seq

Sequential radix-2 restoring divider in the execute stage that executes the `DIV`/`DIVU` requests issued by the pipeline controller. It:

- consumes the controller's execute-stage `divE` and `hassignE` flags plus the two register operands;
- stalls the pipeline while iterating;
- returns remainder/quotient with a one-cycle HI/LO write strobe for the HI/LO register file.

## Interface

- `WIDTH`, default 32, operand and result width; the iteration counter is sized `$clog2(WIDTH)+1`.

Ports:

- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `divE` in 1: division request for the instruction now in execute; held high while stalled.
- `hassignE` in 1: 1 = signed (`DIV`), 0 = unsigned (`DIVU`); sampled only at start.
- `cancelE` in 1: abort the current operation (execute flush or exception).
- `srcaE` in WIDTH: dividend; sampled only at start.
- `srcbE` in WIDTH: divisor; sampled only at start.
- `stallE` out 1: hold fetch, decode and execute; combinational.
- `hilo_weE` out 1: one-cycle pulse; HI/LO must capture `hiE` and `loE`.
- `hiE` out WIDTH: remainder, registered.
- `loE` out WIDTH: quotient, registered.

## Operation

States are IDLE, BUSY and DONE, held in a 2-bit state register.

IDLE:
- On `divE=1` and `cancelE=0`, latch operands and mode.
- Signed mode: latch absolute values and record `neg_q` = sign(a) XOR sign(b), and `neg_r` = sign(a).
- If `srcbE==0`, go to DONE with `loE`=all ones, `hiE`=dividend (raw, unconverted).
- Otherwise clear the counter and go to BUSY.

BUSY:
- Each cycle, shift {rem, quo} left by one and trial-subtract the divisor from rem.
- If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
- Exactly WIDTH iterations run; after the last one, go to DONE.
- On entry to DONE, apply sign correction: two's-complement negate the quotient if `neg_q`, the remainder if `neg_r`.

DONE:
- `hilo_weE=1` for this one cycle.
- `hiE`/`loE` hold the final values.
- Next state is IDLE unconditionally; a request seen in DONE is never restarted.

Signals and arithmetic:
- `stallE` = `divE` & ~`cancelE` & (state != DONE).
- `cancelE=1` in any state: next state is IDLE and no `hilo_weE` is produced. `cancelE` has priority over start and completion.
- Signed overflow (most-negative / -1) gives `loE`=most-negative and `hiE`=0 with no special case; this falls out of the unsigned magnitude path plus negation.
- `hiE`/`loE` keep their last values until the next DONE. They are valid only when `hilo_weE=1`.

## Timing

- Cycle 0: `divE` rises in IDLE; `stallE=1`; operands are captured.
- Normal division:
  - cycles 1..WIDTH are BUSY with `stallE=1`;
  - cycle WIDTH+1 is DONE with `stallE=0` and `hilo_weE=1`;
  - total stall is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: cycle 1 is DONE; stall lasts 1 cycle.
- Back-to-back divides: the next `divE` in the cycle after DONE (state IDLE) starts a new operation with no bubble.
- Reset values: state=IDLE, counter=0, `hiE`=0, `loE`=0, `hilo_weE`=0, `stallE`=0 (because `divE` is low under reset).
- Reset asserted mid-operation: immediately returns to IDLE. No write occurs, and the operation is not resumed after reset.
- `cancelE` in cycle k: `stallE` is low in cycle k; state is IDLE at cycle k+1.

## Configuration

Macro `DIV_EARLY_OUT_EN`.

Defined:
- In IDLE, if |dividend| < |divisor| with a nonzero divisor, go directly to DONE with `loE`=0 and `hiE`=original dividend (sign preserved).
- Stall is 1 cycle.

Not defined:
- Every nonzero-divisor operation takes the full WIDTH+1-cycle path, giving fixed latency.
- The results are identical either way; only latency differs.

## Test plan

- Unsigned, `srcaE`=100, `srcbE`=7, `hassignE`=0: `stallE` high for 33 cycles; `hilo_weE` at cycle 33 with `loE`=14 and `hiE`=2.
- Signed, -7 / 2: `loE`=0xFFFFFFFD and `hiE`=0xFFFFFFFF. Signed 7 / -2: `loE`=0xFFFFFFFD and `hiE`=1.
- Signed 0x80000000 / 0xFFFFFFFF: `loE`=0x80000000 and `hiE`=0. Unsigned, same operands: `loE`=0 and `hiE`=0x80000000 (latency 1 cycle with `DIV_EARLY_OUT_EN`, otherwise 33).
- Divide by zero, 0x1234 / 0: `stallE` for 1 cycle; then `hilo_weE` with `loE`=0xFFFFFFFF and `hiE`=0x1234.
- Cancel and reset:
  - `cancelE` pulse at BUSY cycle 10: `stallE` drops that cycle, no `hilo_weE` ever follows, and a fresh 100/7 then completes correctly.
  - `rst` pulse mid-BUSY: all outputs are 0 during reset, and the unit is IDLE after release.
- Back-to-back: two divides with `divE` re-asserted in the cycle after DONE. Each produces exactly one `hilo_weE` with correct values, and there is no idle bubble between them.

Source files
------------

// File: rtl/div_if.sv
// Execute-stage divider handshake: request/operands from the pipeline controller,
// stall, HI/LO write strobe and results back from the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             divE;
    logic             hassignE;
    logic             cancelE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stallE;
    logic             hilo_weE;
    logic [WIDTH-1:0] hiE;
    logic [WIDTH-1:0] loE;

    modport master (
        output divE,
        output hassignE,
        output cancelE,
        output srcaE,
        output srcbE,
        input  stallE,
        input  hilo_weE,
        input  hiE,
        input  loE
    );

    modport slave (
        input  divE,
        input  hassignE,
        input  cancelE,
        input  srcaE,
        input  srcbE,
        output stallE,
        output hilo_weE,
        output hiE,
        output loE
    );
endinterface

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU (HI = remainder, LO = quotient).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave dif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shift_w, diff_w;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // Operand magnitudes; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude and makes signed overflow fall out naturally.
    assign sgn_a = dif.hassignE & dif.srcaE[WIDTH-1];
    assign sgn_b = dif.hassignE & dif.srcbE[WIDTH-1];
    assign mag_a = cond_neg(dif.srcaE, sgn_a);
    assign mag_b = cond_neg(dif.srcbE, sgn_b);

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        shift_w = {rem_q, quo_q[WIDTH-1]};
        diff_w  = shift_w - {1'b0, dvs_q};
        rem_nx  = shift_w[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff_w[WIDTH]) begin
            rem_nx = diff_w[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (dif.divE) begin
                    if (dif.srcbE == '0) begin
                        state_d = DONE;
                        lo_d    = '1;
                        hi_d    = dif.srcaE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (mag_a < mag_b) begin
                        state_d = DONE;
                        lo_d    = '0;
                        hi_d    = dif.srcaE;
`endif
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = mag_a;
                        dvs_d   = mag_b;
                        neg_q_d = sgn_a ^ sgn_b;
                        neg_r_d = sgn_a;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    hi_d    = cond_neg(rem_nx, neg_r_q);
                    lo_d    = cond_neg(quo_nx, neg_q_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush overrides both a start and a completion; results stay untouched.
        if (dif.cancelE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working datapath registers are only meaningful while BUSY, so no reset.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
    end

    assign dif.stallE   = dif.divE & ~dif.cancelE & (state_q != DONE);
    assign dif.hilo_weE = (state_q == DONE) & ~dif.cancelE;
    assign dif.hiE      = hi_q;
    assign dif.loE      = lo_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: unsigned/signed results, overflow, divide by zero,
// cancel, mid-operation reset and back-to-back requests.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    div_if #(.WIDTH(32)) dif ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int SMALL_STALL = 1;
`else
    localparam int SMALL_STALL = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the unit in IDLE; returns just after
    // the edge that follows DONE, leaving divE low.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] elo, input logic [31:0] ehi,
                          input int estall);
        int n    = 0;
        bit done = 1'b0;
        dif.divE     = 1'b1;
        dif.hassignE = sgn;
        dif.srcaE    = a;
        dif.srcbE    = b;
        dif.cancelE  = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (dif.hilo_weE === 1'b1) begin
                done = 1'b1;
            end else begin
                if (dif.stallE === 1'b1) n++;
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_stall_at_done"}, {31'd0, dif.stallE}, 32'd0);
        chk({tag, "_stall_cycles"}, n, estall);
        chk({tag, "_lo"}, dif.loE, elo);
        chk({tag, "_hi"}, dif.hiE, ehi);
        @(posedge clk);
        #1;
        dif.divE = 1'b0;
        chk({tag, "_single_we"}, {31'd0, dif.hilo_weE}, 32'd0);
    endtask

    task automatic watch_no_we(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (dif.hilo_weE !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        dif.divE     = 1'b0;
        dif.hassignE = 1'b0;
        dif.cancelE  = 1'b0;
        dif.srcaE    = '0;
        dif.srcbE    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, dif.stallE}, 32'd0);
        chk("rst_we", {31'd0, dif.hilo_weE}, 32'd0);
        chk("rst_hi", dif.hiE, 32'd0);
        chk("rst_lo", dif.loE, 32'd0);
        rst = 1'b0;

        do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
        do_div("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
        do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
        do_div("u_small", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, SMALL_STALL);
        do_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);
        do_div("dz_u", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1);
        do_div("dz_s", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1);

        // Cancel at BUSY cycle 10 of a 100/7.
        dif.divE     = 1'b1;
        dif.hassignE = 1'b0;
        dif.srcaE    = 32'd100;
        dif.srcbE    = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        dif.cancelE = 1'b1;
        #1;
        chk("cancel_stall_drop", {31'd0, dif.stallE}, 32'd0);
        chk("cancel_we", {31'd0, dif.hilo_weE}, 32'd0);
        @(posedge clk);
        #1;
        dif.cancelE = 1'b0;
        dif.divE    = 1'b0;
        watch_no_we("cancel_no_we", 40);
        chk("cancel_lo_kept", dif.loE, 32'hFFFF_FFFF);
        chk("cancel_hi_kept", dif.hiE, 32'hFFFF_FF00);
        do_div("after_cancel", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);

        // Asynchronous reset in the middle of BUSY.
        dif.divE     = 1'b1;
        dif.hassignE = 1'b1;
        dif.srcaE    = 32'hFFFF_FFF9;
        dif.srcbE    = 32'd2;
        repeat (5) @(posedge clk);
        #3;
        rst      = 1'b1;
        dif.divE = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, dif.stallE}, 32'd0);
        chk("midrst_we", {31'd0, dif.hilo_weE}, 32'd0);
        chk("midrst_hi", dif.hiE, 32'd0);
        chk("midrst_lo", dif.loE, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        watch_no_we("midrst_no_we", 40);
        chk("midrst_hi_after", dif.hiE, 32'd0);
        do_div("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);

        // Back-to-back: second request in the cycle right after DONE.
        do_div("b2b_a", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 33);
        do_div("b2b_b", 32'hFFFF_FC18, 32'd33, 1'b1, 32'hFFFF_FFE2, 32'hFFFF_FFF6, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
